// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: the fetch stage drives the strobe and address,
// and the memory returns data one cycle after the strobe.
interface fetch_stage_if #(
  parameter int PC_W = 9
);
  logic            rd_en;
  logic [PC_W-1:0] addr;
  logic [31:0]     rdata;

  modport master (output rd_en, output addr, input rdata);
  modport slave  (input rd_en, input addr, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory read issue, a
// 1-entry skid buffer for responses that land during a stall, and the IF/ID
// pipeline register.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   RUN    | fetching; PC advances by 4 per unstalled cycle
//   HALTED | decode saw a halt; no reads, redirects ignored until reset
module fetch_stage #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             pc_sel,
  input  logic [31:0]      br_pc,
  input  logic             halt,
  fetch_stage_if.master    imem,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [31:0]      if_instr,
  output logic             halted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            req_vld;
  logic [PC_W-1:0] req_pc;
  logic            skid_vld;
  logic [PC_W-1:0] skid_pc;
  logic [31:0]     skid_instr;

  logic run;
  logic flush;
  logic halt_now;
  logic drop;
  logic issue;

  // Only the low PC_W bits of the redirect target address the memory.
  logic unused_br_pc_hi;
  assign unused_br_pc_hi = ^br_pc[31:PC_W];

  // Redirects and halts only matter while running; once halted, everything
  // in flight is discarded. Reset gates the strobe so no read leaves early.
  assign run      = (state == RUN);
  assign flush    = pc_sel & run;
  assign halt_now = halt & run;
  assign drop     = flush | halt_now | ~run;
  assign issue    = rst_n & run & ~stall & ~flush & ~halt;

  assign imem.rd_en = issue;
  assign imem.addr  = pc_q;

  // Next-PC select: redirect beats everything, then hold, then sequential.
  always_comb begin
    pc_d = pc_q;
    if (flush)
      pc_d = br_pc[PC_W-1:0];
    else if (halt_now || !run || stall)
      pc_d = pc_q;
    else if (issue)
      pc_d = pc_q + PC_W'(4);
  end

  // Run/halt state machine with registered halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt && !pc_sel) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // PC, outstanding-read tracking, skid buffer and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_vld    <= 1'b0;
      req_pc     <= '0;
      skid_vld   <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= '0;
    end else begin
      pc_q    <= pc_d;
      req_vld <= issue;
      req_pc  <= pc_q;
      if (drop) begin
        // Wrong-path or post-halt: squash IF/ID, the skid and the response.
        if_valid <= 1'b0;
        skid_vld <= 1'b0;
      end else if (stall) begin
        // IF/ID holds; a response arriving now parks in the skid.
        if (req_vld) begin
          skid_vld   <= 1'b1;
          skid_pc    <= req_pc;
          skid_instr <= imem.rdata;
        end
      end else if (skid_vld) begin
        if_valid <= 1'b1;
        if_pc    <= skid_pc;
        if_instr <= skid_instr;
        skid_vld <= 1'b0;
      end else if (req_vld) begin
        if_valid <= 1'b1;
        if_pc    <= req_pc;
        if_instr <= imem.rdata;
      end else begin
        if_valid <= 1'b0;
      end
    end
  end

  // The skid holds one entry: a parked response must drain before another
  // response can arrive, stalled or not.
  always @(posedge clk) begin
    if (rst_n && req_vld && !drop) begin
      assert (!skid_vld);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall with skid, redirect
// under stall, PC wrap, halt, halt+redirect, and asynchronous reset.
module tb_fetch_stage;

  localparam int PC_W = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        pc_sel;
  logic [31:0] br_pc;
  logic        halt;
  logic        if_valid;
  logic [8:0]  if_pc;
  logic [31:0] if_instr;
  logic        halted;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  fetch_stage_if #(.PC_W(PC_W)) bus ();

  fetch_stage #(.PC_W(PC_W), .RESET_PC(9'h000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .pc_sel   (pc_sel),
    .br_pc    (br_pc),
    .halt     (halt),
    .imem     (bus.master),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Instruction word stored at a byte address: unique per address.
  function automatic logic [31:0] ins(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  // Synchronous instruction memory: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.rd_en) mem_rdata <= ins(bus.addr);
  end
  assign bus.rdata = mem_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_if(input string tag, input logic [8:0] pc);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_pc"}, {23'd0, if_pc}, {23'd0, pc});
    chk({tag, "_instr"}, if_instr, ins(pc));
  endtask

  initial begin
    mem_rdata = 32'hDEAD_BEEF;
    rst_n  = 1'b0;
    stall  = 1'b0;
    pc_sel = 1'b0;
    br_pc  = 32'd0;
    halt   = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", {23'd0, if_pc}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_rden", {31'd0, bus.rd_en}, 32'd0);
    chk("rst_addr", {23'd0, bus.addr}, 32'd0);

    // 1: sequential fetch after release
    rst_n = 1'b1;
    #1;
    chk("seq_addr0", {23'd0, bus.addr}, 32'h000);
    chk("seq_rden0", {31'd0, bus.rd_en}, 32'd1);
    tick();                                           // edge 1
    chk("seq_addr1", {23'd0, bus.addr}, 32'h004);
    chk("seq_v1", {31'd0, if_valid}, 32'd0);
    tick();                                           // edge 2
    chk("seq_addr2", {23'd0, bus.addr}, 32'h008);
    chk_if("seq_e2", 9'h000);
    tick();                                           // edge 3
    chk("seq_addr3", {23'd0, bus.addr}, 32'h00C);
    chk_if("seq_e3", 9'h004);

    // 2: three stall cycles with the read of 0x008 in flight
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin                 // edges 4..6
      tick();
      chk("stl_pc", {23'd0, if_pc}, 32'h004);
      chk("stl_valid", {31'd0, if_valid}, 32'd1);
      chk("stl_addr", {23'd0, bus.addr}, 32'h00C);
      chk("stl_rden", {31'd0, bus.rd_en}, 32'd0);
    end
    stall = 1'b0;
    tick();                                           // edge 7
    chk_if("unstl_skid", 9'h008);
    tick();                                           // edge 8
    chk_if("unstl_n1", 9'h00C);
    tick();                                           // edge 9
    chk_if("unstl_n2", 9'h010);

    // 3: redirect to 0x40 while stalled
    stall  = 1'b1;
    pc_sel = 1'b1;
    br_pc  = 32'h0000_0040;
    tick();                                           // edge 10
    chk("rd_v0", {31'd0, if_valid}, 32'd0);
    chk("rd_addr0", {23'd0, bus.addr}, 32'h040);
    stall  = 1'b0;
    pc_sel = 1'b0;
    tick();                                           // edge 11
    chk("rd_v1", {31'd0, if_valid}, 32'd0);
    chk("rd_addr1", {23'd0, bus.addr}, 32'h044);
    tick();                                           // edge 12
    chk_if("rd_tgt", 9'h040);

    // 4: PC wrap; upper redirect bits must be ignored
    pc_sel = 1'b1;
    br_pc  = 32'hFFFF_F1F8;
    tick();                                           // edge 13
    pc_sel = 1'b0;
    chk("wr_addr0", {23'd0, bus.addr}, 32'h1F8);
    tick();                                           // edge 14
    chk("wr_addr1", {23'd0, bus.addr}, 32'h1FC);
    tick();                                           // edge 15
    chk("wr_addr2", {23'd0, bus.addr}, 32'h000);
    chk_if("wr_if0", 9'h1F8);
    tick();                                           // edge 16
    chk_if("wr_if1", 9'h1FC);
    tick();                                           // edge 17
    chk_if("wr_if2", 9'h000);
    chk("wr_addr3", {23'd0, bus.addr}, 32'h008);

    // 6a: halt together with redirect - redirect wins
    halt   = 1'b1;
    pc_sel = 1'b1;
    br_pc  = 32'h0000_0100;
    #1;
    chk("hp_rden", {31'd0, bus.rd_en}, 32'd0);
    tick();                                           // edge 18
    halt   = 1'b0;
    pc_sel = 1'b0;
    chk("hp_halted", {31'd0, halted}, 32'd0);
    chk("hp_addr", {23'd0, bus.addr}, 32'h100);
    chk("hp_v0", {31'd0, if_valid}, 32'd0);
    tick();                                           // edge 19
    chk("hp_v1", {31'd0, if_valid}, 32'd0);
    tick();                                           // edge 20
    chk_if("hp_tgt", 9'h100);

    // 5: halt, then an ignored redirect
    halt = 1'b1;
    #1;
    chk("h_rden_pre", {31'd0, bus.rd_en}, 32'd0);
    tick();                                           // edge 21
    halt = 1'b0;
    chk("h_halted", {31'd0, halted}, 32'd1);
    chk("h_valid", {31'd0, if_valid}, 32'd0);
    chk("h_addr", {23'd0, bus.addr}, 32'h108);
    pc_sel = 1'b1;
    br_pc  = 32'h0000_0080;
    tick();                                           // edge 22
    pc_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("h_keep_halted", {31'd0, halted}, 32'd1);
      chk("h_keep_rden", {31'd0, bus.rd_en}, 32'd0);
      chk("h_keep_valid", {31'd0, if_valid}, 32'd0);
      chk("h_keep_addr", {23'd0, bus.addr}, 32'h108);
      tick();
    end

    // 6b: reset leaves HALTED; then async reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("ar_halted", {31'd0, halted}, 32'd0);
    chk("ar_addr", {23'd0, bus.addr}, 32'h000);
    rst_n = 1'b1;
    tick();
    tick();
    chk_if("ar_run0", 9'h000);
    tick();
    chk_if("ar_run1", 9'h004);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_mid_valid", {31'd0, if_valid}, 32'd0);
    chk("ar_mid_pc", {23'd0, if_pc}, 32'd0);
    chk("ar_mid_rden", {31'd0, bus.rd_en}, 32'd0);
    chk("ar_mid_addr", {23'd0, bus.addr}, 32'h000);
    rst_n = 1'b1;
    tick();
    chk("ar_re_v", {31'd0, if_valid}, 32'd0);
    tick();
    chk_if("ar_re_if", 9'h000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
